// File: rtl/axis_insert_arbiter_if.sv
// ----------------------------------------------------------------------------
// axis_insert_arbiter_if
// Bundles the per-source header/payload AXI-Stream channels and the single
// shared header/payload channel that the arbiter drives toward the shared
// insert-header block.
//   s_*_insert : NUM_SRC header channels (valid/header/keep in, ready out)
//   s_*_in     : NUM_SRC payload channels (valid/data/keep/last in, ready out)
//   m_*_insert : shared header channel (valid/header/keep out, ready in)
//   m_*_in     : shared payload channel (valid/data/keep/last out, ready in)
// Modports:
//   slave  : the arbiter's view
//   master : the surrounding environment (sources + shared block)
// ----------------------------------------------------------------------------
interface axis_insert_arbiter_if #(
    parameter int NUM_SRC      = 4,
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8
);
    logic [NUM_SRC-1:0]              s_valid_insert;
    logic [NUM_SRC*DATA_WD-1:0]      s_header_insert;
    logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep_insert;
    logic [NUM_SRC-1:0]              s_ready_insert;

    logic [NUM_SRC-1:0]              s_valid_in;
    logic [NUM_SRC*DATA_WD-1:0]      s_data_in;
    logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep_in;
    logic [NUM_SRC-1:0]              s_last_in;
    logic [NUM_SRC-1:0]              s_ready_in;

    logic                            m_valid_insert;
    logic [DATA_WD-1:0]              m_header_insert;
    logic [DATA_BYTE_WD-1:0]         m_keep_insert;
    logic                            m_ready_insert;

    logic                            m_valid_in;
    logic [DATA_WD-1:0]              m_data_in;
    logic [DATA_BYTE_WD-1:0]         m_keep_in;
    logic                            m_last_in;
    logic                            m_ready_in;

    modport slave (
        input  s_valid_insert, s_header_insert, s_keep_insert,
        output s_ready_insert,
        input  s_valid_in, s_data_in, s_keep_in, s_last_in,
        output s_ready_in,
        output m_valid_insert, m_header_insert, m_keep_insert,
        input  m_ready_insert,
        output m_valid_in, m_data_in, m_keep_in, m_last_in,
        input  m_ready_in
    );

    modport master (
        output s_valid_insert, s_header_insert, s_keep_insert,
        input  s_ready_insert,
        output s_valid_in, s_data_in, s_keep_in, s_last_in,
        input  s_ready_in,
        input  m_valid_insert, m_header_insert, m_keep_insert,
        output m_ready_insert,
        input  m_valid_in, m_data_in, m_keep_in, m_last_in,
        output m_ready_in
    );
endinterface

// File: rtl/axis_insert_arbiter.sv
// ----------------------------------------------------------------------------
// axis_insert_arbiter
// Round-robin arbiter that lets NUM_SRC sources share one insert-header block.
// A source requests by raising its header valid; the winner owns the shared
// channel for its header and then its whole payload up to the last beat.
// Ports:
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   bus      : axis_insert_arbiter_if.slave (all per-source and shared channels)
//   grant_id : index of the current owner, held while idle
//   busy     : high while a packet (header or payload) is in flight
//   pkt_cnt  : number of completed packets, wraps at 16 bits
// ----------------------------------------------------------------------------
module axis_insert_arbiter #(
    parameter int NUM_SRC      = 4,
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8
) (
    input  logic                       clk,
    input  logic                       rst,
    axis_insert_arbiter_if.slave       bus,
    output logic [$clog2(NUM_SRC)-1:0] grant_id,
    output logic                       busy,
    output logic [15:0]                pkt_cnt
);
    localparam int ID_WD = $clog2(NUM_SRC);
    localparam logic [ID_WD-1:0] LAST_ID = ID_WD'(NUM_SRC - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [ID_WD-1:0] r_grant;
    logic [ID_WD-1:0] r_rr_ptr;
    logic [15:0]      r_pkt_cnt;
    logic [ID_WD-1:0] w_pick;
    logic             w_any_req;
    logic             w_hdr_fire;
    logic             w_last_fire;

    // First requester at or after ptr, scanning upward and wrapping to 0.
    function automatic logic [ID_WD-1:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                                 input logic [ID_WD-1:0]   ptr);
        logic [ID_WD-1:0] sel;
        logic             found;
        int               idx;
        sel   = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx   = (int'(ptr) + k) % NUM_SRC;
            sel   = (!found && req[idx]) ? ID_WD'(idx) : sel;
            found = found | req[idx];
        end
        return sel;
    endfunction

    assign w_any_req   = |bus.s_valid_insert;
    assign w_pick      = rr_pick(bus.s_valid_insert, r_rr_ptr);
    assign w_hdr_fire  = (r_state == ST_HEADER) && bus.s_valid_insert[r_grant] && bus.m_ready_insert;
    assign w_last_fire = (r_state == ST_PAYLOAD) && bus.s_valid_in[r_grant] &&
                         bus.m_ready_in && bus.s_last_in[r_grant];

    assign grant_id = r_grant;
    assign busy     = (r_state != ST_IDLE);
    assign pkt_cnt  = r_pkt_cnt;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Grant latch on arbitration, pointer advance and packet count on the last beat
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant   <= {ID_WD{1'b0}};
            r_rr_ptr  <= {ID_WD{1'b0}};
            r_pkt_cnt <= 16'd0;
        end else begin
            if ((r_state == ST_IDLE) && w_any_req) begin
                r_grant <= w_pick;
            end
            if (w_last_fire) begin
                r_rr_ptr  <= (r_grant == LAST_ID) ? {ID_WD{1'b0}} : (r_grant + 1'b1);
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
            end
        end
    end

    // FSM next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) w_next_state = ST_HEADER;
                else           w_next_state = ST_IDLE;
            end
            ST_HEADER: begin
                if (w_hdr_fire) w_next_state = ST_PAYLOAD;
                else            w_next_state = ST_HEADER;
            end
            ST_PAYLOAD: begin
                if (w_last_fire) w_next_state = ST_IDLE;
                else             w_next_state = ST_PAYLOAD;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM outputs: route the granted source through; valids and readies gated by phase
    always_comb begin
        bus.s_ready_insert  = {NUM_SRC{1'b0}};
        bus.s_ready_in      = {NUM_SRC{1'b0}};
        bus.m_valid_insert  = 1'b0;
        bus.m_valid_in      = 1'b0;
        // Data fields always follow the owner; they only matter when valid is high.
        bus.m_header_insert = bus.s_header_insert[int'(r_grant)*DATA_WD +: DATA_WD];
        bus.m_keep_insert   = bus.s_keep_insert[int'(r_grant)*DATA_BYTE_WD +: DATA_BYTE_WD];
        bus.m_data_in       = bus.s_data_in[int'(r_grant)*DATA_WD +: DATA_WD];
        bus.m_keep_in       = bus.s_keep_in[int'(r_grant)*DATA_BYTE_WD +: DATA_BYTE_WD];
        bus.m_last_in       = bus.s_last_in[r_grant];
        case (r_state)
            ST_IDLE: begin
                bus.m_valid_insert = 1'b0;
            end
            ST_HEADER: begin
                // Payload ready stays 0 here so early payload beats are held upstream.
                bus.m_valid_insert          = bus.s_valid_insert[r_grant];
                bus.s_ready_insert[r_grant] = bus.m_ready_insert;
            end
            ST_PAYLOAD: begin
                bus.m_valid_in          = bus.s_valid_in[r_grant];
                bus.s_ready_in[r_grant] = bus.m_ready_in;
            end
            default: begin
                bus.m_valid_in = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_axis_insert_arbiter.sv
module tb_axis_insert_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int KW = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] grant_id;
    logic          busy;
    logic [15:0]   pkt_cnt;

    always #5 clk = ~clk;

    axis_insert_arbiter_if #(.NUM_SRC(N), .DATA_WD(DW), .DATA_BYTE_WD(KW)) bus ();

    axis_insert_arbiter #(.NUM_SRC(N), .DATA_WD(DW), .DATA_BYTE_WD(KW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .grant_id (grant_id),
        .busy     (busy),
        .pkt_cnt  (pkt_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- source behaviour ----------------
    bit         src_act [N];
    bit         src_hdr_done [N];
    bit         src_mask [N];
    int         src_beat [N];
    int         src_n [N];
    int         src_tag [N];
    int         src_reps [N];
    logic [31:0] src_hdr [N];
    logic [3:0]  src_hk [N];
    logic [3:0]  src_lk [N];
    bit         hs_hdr [N];
    bit         hs_pay [N];
    bit         rnd_ready = 1'b0;

    function automatic logic [31:0] beat_data(input int s, input int t, input int b);
        return {s[7:0], t[7:0], 8'h00, b[7:0]};
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.s_valid_insert[i]             = src_act[i] && !src_hdr_done[i] && !src_mask[i];
            bus.s_header_insert[i*DW +: DW]   = src_hdr[i];
            bus.s_keep_insert[i*KW +: KW]     = src_hk[i];
            bus.s_valid_in[i]                 = src_act[i] && (src_beat[i] < src_n[i]);
            bus.s_data_in[i*DW +: DW]         = beat_data(i, src_tag[i], src_beat[i]);
            bus.s_keep_in[i*KW +: KW]         = (src_beat[i] == src_n[i] - 1) ? src_lk[i] : 4'hF;
            bus.s_last_in[i]                  = src_act[i] && (src_beat[i] == src_n[i] - 1);
        end
    endtask

    task automatic clr_src();
        for (int i = 0; i < N; i++) begin
            src_act[i] = 1'b0; src_hdr_done[i] = 1'b0; src_mask[i] = 1'b0;
            src_beat[i] = 0; src_n[i] = 1; src_tag[i] = 0; src_reps[i] = 0;
            src_hdr[i] = 32'h0; src_hk[i] = 4'h0; src_lk[i] = 4'h0;
        end
        drive();
    endtask

    task automatic load(input int s, input logic [31:0] h, input logic [3:0] hk, input int nb,
                        input logic [3:0] lk, input int tag, input int reps);
        src_act[s] = 1'b1; src_hdr_done[s] = 1'b0; src_mask[s] = 1'b0; src_beat[s] = 0;
        src_n[s] = nb; src_tag[s] = tag; src_reps[s] = reps;
        src_hdr[s] = h; src_hk[s] = hk; src_lk[s] = lk;
        drive();
    endtask

    // One clock: apply handshakes seen before the edge, then present new inputs.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs_hdr[i]) src_hdr_done[i] = 1'b1;
            if (hs_pay[i]) begin
                if (src_beat[i] == src_n[i] - 1) begin
                    if (src_reps[i] > 0) begin
                        src_reps[i]--; src_tag[i]++; src_hdr_done[i] = 1'b0; src_beat[i] = 0;
                    end else begin
                        src_act[i] = 1'b0;
                    end
                end else begin
                    src_beat[i]++;
                end
            end
        end
        if (rnd_ready) bus.m_ready_in = 1'($urandom_range(0, 1));
        drive();
    endtask

    // ---------------- behavioural model ----------------
    int mdl_owner = -1;   // -1: nobody owns the shared block
    int mdl_grant = 0;
    int mdl_rr    = 0;
    int mdl_cnt   = 0;
    bit mdl_pay   = 1'b0; // owner's header already delivered
    bit mdl_ok    = 1'b0;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            mdl_owner = -1; mdl_grant = 0; mdl_rr = 0; mdl_cnt = 0; mdl_pay = 1'b0; mdl_ok = 1'b1;
        end else if (mdl_ok) begin
            if (mdl_owner < 0) begin
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (mdl_rr + k) % N;
                    if (mdl_owner < 0 && bus.s_valid_insert[idx]) mdl_owner = idx;
                end
                if (mdl_owner >= 0) begin
                    mdl_grant = mdl_owner;
                    mdl_pay   = 1'b0;
                end
            end else if (!mdl_pay) begin
                if (bus.s_valid_insert[mdl_owner] && bus.m_ready_insert) mdl_pay = 1'b1;
            end else if (bus.s_valid_in[mdl_owner] && bus.m_ready_in && bus.s_last_in[mdl_owner]) begin
                mdl_rr    = (mdl_owner + 1) % N;
                mdl_cnt   = (mdl_cnt + 1) % 65536;
                mdl_owner = -1;
            end
        end
    end

    // ---------------- observation logs ----------------
    int          grant_log[$];
    logic [31:0] hdr_log[$];
    logic [3:0]  hk_log[$];
    logic [31:0] beat_log[$];
    logic [3:0]  keep_log[$];
    int          phase_log[$];

    task automatic clr_logs();
        grant_log.delete(); hdr_log.delete(); hk_log.delete();
        beat_log.delete(); keep_log.delete(); phase_log.delete();
    endtask

    // Compare process: mid-cycle, every cycle once the model has seen reset.
    initial forever begin
        logic [N-1:0] exp_ri, exp_rin;
        logic         exp_mvi, exp_mvin;
        int           code;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            hs_hdr[i] = bus.s_valid_insert[i] & bus.s_ready_insert[i];
            hs_pay[i] = bus.s_valid_in[i] & bus.s_ready_in[i];
        end
        if (mdl_ok) begin
            exp_ri = '0; exp_rin = '0; exp_mvi = 1'b0; exp_mvin = 1'b0;
            if (mdl_owner >= 0) begin
                if (!mdl_pay) begin
                    exp_ri[mdl_owner] = bus.m_ready_insert;
                    exp_mvi           = bus.s_valid_insert[mdl_owner];
                end else begin
                    exp_rin[mdl_owner] = bus.m_ready_in;
                    exp_mvin           = bus.s_valid_in[mdl_owner];
                end
            end
            chk("busy", busy, mdl_owner >= 0);
            chk("grant_id", grant_id, mdl_grant);
            chk("pkt_cnt", pkt_cnt, mdl_cnt);
            chk("s_ready_insert", bus.s_ready_insert, exp_ri);
            chk("s_ready_in", bus.s_ready_in, exp_rin);
            chk("m_valid_insert", bus.m_valid_insert, exp_mvi);
            chk("m_valid_in", bus.m_valid_in, exp_mvin);
            if (exp_mvi) begin
                chk("m_header_insert", bus.m_header_insert, bus.s_header_insert[mdl_owner*DW +: DW]);
                chk("m_keep_insert", bus.m_keep_insert, bus.s_keep_insert[mdl_owner*KW +: KW]);
            end
            if (exp_mvin) begin
                chk("m_data_in", bus.m_data_in, bus.s_data_in[mdl_owner*DW +: DW]);
                chk("m_keep_in", bus.m_keep_in, bus.s_keep_in[mdl_owner*KW +: KW]);
                chk("m_last_in", bus.m_last_in, bus.s_last_in[mdl_owner]);
            end
        end
        if (bus.m_valid_insert && bus.m_ready_insert) begin
            grant_log.push_back(int'(grant_id));
            hdr_log.push_back(bus.m_header_insert);
            hk_log.push_back(bus.m_keep_insert);
        end
        if (bus.m_valid_in && bus.m_ready_in) begin
            beat_log.push_back(bus.m_data_in);
            keep_log.push_back(bus.m_keep_in);
        end
        code = !busy ? 0 : (bus.m_valid_insert ? 1 : (bus.m_valid_in ? 2 : 3));
        if (phase_log.size() == 0 || phase_log[phase_log.size()-1] != code) phase_log.push_back(code);
    end

    function automatic bit any_active();
        bit a;
        a = (mdl_owner >= 0);
        for (int i = 0; i < N; i++) a = a | src_act[i];
        return a;
    endfunction

    task automatic run_until_done(input string name, input int max);
        int c;
        c = 0;
        while (any_active() && c < max) begin
            step();
            c++;
        end
        chk(name, c < max, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int c;
        int exp_b[10];
        int exp_d[7];
        rst = 1'b1;
        bus.m_ready_insert = 1'b1;
        bus.m_ready_in     = 1'b1;
        clr_src();
        clr_logs();
        repeat (3) step();

        // reset state
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant", grant_id, 2'd0);
        chk("rst_cnt", pkt_cnt, 16'd0);
        chk("rst_mvi", bus.m_valid_insert, 1'b0);
        chk("rst_mvin", bus.m_valid_in, 1'b0);
        chk("rst_sri", bus.s_ready_insert, 4'b0000);
        chk("rst_srin", bus.s_ready_in, 4'b0000);

        // single source, header then 5 beats
        rst = 1'b0;
        clr_logs();
        load(1, 32'hA5A5A5A5, 4'b0011, 5, 4'b1100, 1, 0);
        step();
        chk("a_grant_after_1", grant_id, 2'd1);
        chk("a_busy_after_1", busy, 1'b1);
        run_until_done("a_done", 100);
        chk("a_ngrant", grant_log.size(), 1);
        chk("a_grant", grant_log[0], 1);
        chk("a_hdr", hdr_log[0], 32'hA5A5A5A5);
        chk("a_hkeep", hk_log[0], 4'b0011);
        chk("a_nbeats", beat_log.size(), 5);
        chk("a_beat0", beat_log[0], 32'h01010000);
        chk("a_beat4", beat_log[4], 32'h01010004);
        chk("a_keep0", keep_log[0], 4'hF);
        chk("a_keep4", keep_log[4], 4'b1100);
        chk("a_cnt", pkt_cnt, 16'd1);

        // all sources request from reset
        rst = 1'b1;
        load(0, 32'h00000010, 4'hF, 2, 4'h3, 0, 1);
        load(1, 32'h00000011, 4'hF, 2, 4'h3, 0, 0);
        load(2, 32'h00000012, 4'hF, 2, 4'h3, 0, 0);
        load(3, 32'h00000013, 4'hF, 2, 4'h3, 0, 0);
        repeat (2) step();
        rst = 1'b0;
        clr_logs();
        run_until_done("b_done", 200);
        chk("b_ngrant", grant_log.size(), 5);
        chk("b_g0", grant_log[0], 0);
        chk("b_g1", grant_log[1], 1);
        chk("b_g2", grant_log[2], 2);
        chk("b_g3", grant_log[3], 3);
        chk("b_g4", grant_log[4], 0);
        chk("b_cnt", pkt_cnt, 16'd5);
        exp_b = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        chk("b_nbeats", beat_log.size(), 10);
        for (int j = 0; j < 10; j++) chk("b_contig", beat_log[j][31:24], exp_b[j]);

        // random m_ready_in during a 4-beat packet from src2
        clr_logs();
        rnd_ready = 1'b1;
        load(2, 32'h22222222, 4'hF, 4, 4'h7, 5, 0);
        run_until_done("c_done", 300);
        rnd_ready = 1'b0;
        bus.m_ready_in = 1'b1;
        drive();
        chk("c_nbeats", beat_log.size(), 4);
        for (int j = 0; j < 4; j++) chk("c_beat", beat_log[j], {8'd2, 8'd5, 8'd0, 8'(j)});
        chk("c_cnt", pkt_cnt, 16'd6);

        // src3 owns; src0 and src1 request mid-packet -> 3, then wrap to 0, then 1
        clr_logs();
        load(3, 32'h33333333, 4'hF, 3, 4'hF, 7, 0);
        c = 0;
        while (!(mdl_owner == 3 && mdl_pay) && c < 50) begin step(); c++; end
        chk("d_reach_payload", c < 50, 1'b1);
        load(0, 32'h00000000, 4'hF, 2, 4'hF, 8, 0);
        load(1, 32'h11111111, 4'hF, 2, 4'hF, 9, 0);
        run_until_done("d_done", 200);
        chk("d_ngrant", grant_log.size(), 3);
        chk("d_g0", grant_log[0], 3);
        chk("d_g1", grant_log[1], 0);
        chk("d_g2", grant_log[2], 1);
        exp_d = '{3, 3, 3, 0, 0, 1, 1};
        chk("d_nbeats", beat_log.size(), 7);
        for (int j = 0; j < 7; j++) chk("d_contig", beat_log[j][31:24], exp_d[j]);
        chk("d_cnt", pkt_cnt, 16'd9);

        // header valid dropped while in HEADER; payload valid must be stalled
        clr_logs();
        load(0, 32'h0000AAAA, 4'h1, 2, 4'h1, 3, 0);
        c = 0;
        while (mdl_owner != 0 && c < 50) begin step(); c++; end
        chk("e_granted", c < 50, 1'b1);
        src_mask[0] = 1'b1;
        drive();
        repeat (3) step();
        chk("e_busy", busy, 1'b1);
        chk("e_grant", grant_id, 2'd0);
        chk("e_mvi", bus.m_valid_insert, 1'b0);
        chk("e_mvin", bus.m_valid_in, 1'b0);
        chk("e_stall", bus.s_ready_in[0], 1'b0);
        src_mask[0] = 1'b0;
        drive();
        run_until_done("e_done", 100);
        chk("e_nbeats", beat_log.size(), 2);
        chk("e_cnt", pkt_cnt, 16'd10);

        // single-beat packet from src2
        clr_logs();
        load(2, 32'h2000BEEF, 4'hF, 1, 4'b1000, 4, 0);
        run_until_done("f_done", 50);
        step();
        chk("f_nphase", phase_log.size(), 4);
        chk("f_ph0", phase_log[0], 0);
        chk("f_ph1", phase_log[1], 1);
        chk("f_ph2", phase_log[2], 2);
        chk("f_ph3", phase_log[3], 0);
        chk("f_nbeats", beat_log.size(), 1);
        chk("f_keep", keep_log[0], 4'b1000);
        chk("f_cnt", pkt_cnt, 16'd11);

        // reset on the second payload beat of src1
        rst = 1'b1;
        step();
        rst = 1'b0;
        load(1, 32'h1111AAAA, 4'hF, 5, 4'hF, 6, 0);
        c = 0;
        while (src_beat[1] != 1 && c < 50) begin step(); c++; end
        chk("g_reach_beat2", c < 50, 1'b1);
        chk("g_busy_pre", busy, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        clr_src();
        chk("g_busy", busy, 1'b0);
        chk("g_cnt", pkt_cnt, 16'd0);
        chk("g_grant", grant_id, 2'd0);
        repeat (2) step();
        chk("g_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axis_insert_arbiter.md
AXIS_INSERT_ARBITER -- requirements
Module: axis_insert_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4; number of requesting sources, range 2..8.
REQ-002 Parameter DATA_WD, default 32; data width in bits.
REQ-003 Parameter DATA_BYTE_WD, default DATA_WD/8; keep width.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset; synchronous and active-high.
REQ-006 s_valid_insert  in  NUM_SRC  per-source header valid; also the packet request.
REQ-007 s_header_insert  in  NUM_SRC*DATA_WD  per-source header, source i at slice i.
REQ-008 s_keep_insert  in  NUM_SRC*DATA_BYTE_WD  per-source header keep.
REQ-009 s_ready_insert  out  NUM_SRC  per-source header ready.
REQ-010 s_valid_in  in  NUM_SRC  per-source payload valid.
REQ-011 s_data_in  in  NUM_SRC*DATA_WD  per-source payload data.
REQ-012 s_keep_in  in  NUM_SRC*DATA_BYTE_WD  per-source payload keep.
REQ-013 s_last_in  in  NUM_SRC  per-source payload last.
REQ-014 s_ready_in  out  NUM_SRC  per-source payload ready.
REQ-015 m_valid_insert, m_header_insert, m_keep_insert  out  1/DATA_WD/DATA_BYTE_WD  header channel to the shared insert-header block.
REQ-016 m_ready_insert  in  1  header ready from the shared block.
REQ-017 m_valid_in, m_data_in, m_keep_in, m_last_in  out  1/DATA_WD/DATA_BYTE_WD/1  payload channel to the shared block.
REQ-018 m_ready_in  in  1  payload ready from the shared block.
REQ-019 grant_id  out  $clog2(NUM_SRC)  index of the current owner; holds its value in IDLE.
REQ-020 busy  out  1  high in HEADER and PAYLOAD.
REQ-021 pkt_cnt  out  16  count of completed packets.

Function
REQ-022 FSM states: IDLE, HEADER, PAYLOAD.
REQ-023 IDLE: when any s_valid_insert bit is high, the block SHALL select the first requester at or after rr_ptr (round-robin, wrapping NUM_SRC-1 -> 0), register grant_id and enter HEADER on the next edge.
REQ-024 Grant latency SHALL be exactly 1 cycle from the request being visible in IDLE to the HEADER state.
REQ-025 HEADER: m_*_insert SHALL combinationally mirror source grant_id; s_ready_insert[grant_id] = m_ready_insert; on m_valid_insert && m_ready_insert, go to PAYLOAD.
REQ-026 PAYLOAD: m_valid_in/m_data_in/m_keep_in/m_last_in SHALL mirror source grant_id unchanged, keep included; s_ready_in[grant_id] = m_ready_in.
REQ-027 PAYLOAD: on m_valid_in && m_ready_in && m_last_in -> IDLE; rr_ptr <= grant_id+1 (wrap); pkt_cnt += 1, wrapping 0xFFFF -> 0.
REQ-028 Non-granted sources, and every source in IDLE, SHALL see s_ready_insert=0 and s_ready_in=0.
REQ-029 m_valid_insert SHALL be 0 outside HEADER; m_valid_in SHALL be 0 outside PAYLOAD; data/keep/last are don't-care while the matching valid is 0.
REQ-030 Grant SHALL be held until the last beat; s_valid_insert changes on other sources SHALL NOT preempt it.
REQ-031 Payload valid from the granted source during HEADER SHALL be stalled (ready 0), not dropped.
REQ-032 Requester deasserting s_valid_insert while in HEADER: the block SHALL stay in HEADER (no timeout).
REQ-033 A single-beat packet (last on the first payload beat) SHALL return to IDLE after that beat; back-to-back packets therefore have a minimum of 1 IDLE cycle.
REQ-034 No combinational path from m_ready_* to m_valid_*.

Reset
REQ-035 With rst high at a clock edge, the block SHALL set state IDLE, rr_ptr 0, grant_id 0 and pkt_cnt 0; busy, all s_ready_* and all m_valid_* are then 0.
REQ-036 Reset mid-packet SHALL abandon the packet without completing it and without incrementing pkt_cnt.

Verification
REQ-037 Single source: src1 sends header 0xA5A5A5A5/keep 4'b0011 and then 5 beats, last keep 4'b1100, with m_ready_* held at 1 -> grant_id=1; m_* match src1 beat-for-beat; pkt_cnt=1.
REQ-038 All 4 sources request continuously from reset -> grant order 0,1,2,3,0; each packet is contiguous; pkt_cnt=5 after 5 packets.
REQ-039 m_ready_in toggles randomly during a 4-beat packet from src2 -> no beat lost or duplicated; src2's s_ready_in equals m_ready_in; other s_ready_in stay 0.
REQ-040 src3 is granted, then src0 requests mid-packet -> src3 completes, then src0 is granted (rr_ptr wraps from 3 to 0).
REQ-041 rst asserted on the 2nd payload beat of src1 -> next cycle busy=0, pkt_cnt unchanged from its reset value 0, grant_id=0.
REQ-042 src2 sends a 1-beat packet with last=1 and keep 4'b1000 -> state sequence HEADER, PAYLOAD, IDLE; m_keep_in=4'b1000.
